// File: rtl/led_pattern_engine.sv
// Avalon-MM LED pattern engine: static/blink/chase modes stepped by a prescaled tick, optional PWM dimming.
// Build option LED_PATTERN_ENGINE_PWM_EN adds the duty register and PWM gate; without it LEDs run at full brightness.
module led_pattern_engine #(
  parameter int PRESCALE = 50000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        address,
  input  logic        read,
  output logic [31:0] readdata,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [7:0]  leds
);
  localparam int PW = $clog2(PRESCALE);
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    M_STATIC  = 2'b00,
    M_BLINK   = 2'b01,
    M_CHASE_L = 2'b10,
    M_CHASE_R = 2'b11
  } mode_t;

  mode_t         mode;
  logic [7:0]    pattern;
  logic [15:0]   step;
  logic [PW-1:0] presc_cnt;
  logic [15:0]   step_cnt;
  logic [7:0]    work;
  logic          phase;

  logic          wr_ctrl;
  logic          wr_rate;
  logic          tick;
  logic          stepev;
  logic          pwm_on;
  logic [15:0]   step_last;
  logic [7:0]    duty_view;
  logic [7:0]    disp;
  logic [31:0]   ctrl_view;
  logic [31:0]   rate_view;

  assign wr_ctrl   = write & ~address;
  assign wr_rate   = write & address;
  assign tick      = (presc_cnt == PRESC_LAST);
  assign step_last = (step == 16'd0) ? 16'd0 : step - 16'd1;
  // Any register write restarts step timing, so it also swallows a coincident step event.
  assign stepev    = tick & ~write & (step_cnt >= step_last);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_cnt <= '0;
    end else if (tick) begin
      presc_cnt <= '0;
    end else begin
      presc_cnt <= presc_cnt + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pattern <= 8'h00;
      mode    <= M_STATIC;
      step    <= 16'd500;
    end else begin
      if (wr_ctrl) begin
        pattern <= writedata[7:0];
        mode    <= mode_t'(writedata[9:8]);
      end
      if (wr_rate) begin
        step <= writedata[23:8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      step_cnt <= 16'd0;
      work     <= 8'h00;
      phase    <= 1'b1;
    end else if (wr_ctrl) begin
      step_cnt <= 16'd0;
      work     <= writedata[7:0];
      phase    <= 1'b1;
    end else if (wr_rate) begin
      step_cnt <= 16'd0;
    end else if (stepev) begin
      step_cnt <= 16'd0;
      case (mode)
        M_BLINK:   phase <= ~phase;
        M_CHASE_L: work  <= {work[6:0], work[7]};
        M_CHASE_R: work  <= {work[0], work[7:1]};
        default:   ;
      endcase
    end else if (tick) begin
      step_cnt <= step_cnt + 16'd1;
    end
  end

`ifdef LED_PATTERN_ENGINE_PWM_EN
  logic [7:0] duty;
  logic [7:0] pwm_cnt;
  logic       unused_wdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      duty <= 8'hFF;
    end else if (wr_rate) begin
      duty <= writedata[7:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pwm_cnt <= 8'h00;
    end else begin
      pwm_cnt <= pwm_cnt + 8'd1;
    end
  end

  // duty 255 must mean fully on, which the compare alone cannot express.
  assign pwm_on       = (pwm_cnt < duty) | (duty == 8'hFF);
  assign duty_view    = duty;
  assign unused_wdata = &{1'b0, writedata[31:24]};
`else
  logic unused_wdata;

  assign pwm_on       = 1'b1;
  assign duty_view    = 8'hFF;
  assign unused_wdata = &{1'b0, writedata[31:24], writedata[7:0]};
`endif

  always_comb begin
    disp = work;
    if (mode == M_BLINK && !phase) begin
      disp = 8'h00;
    end
  end

  assign ctrl_view = {22'd0, mode, pattern};
  assign rate_view = {8'd0, step, duty_view};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= 32'd0;
      leds     <= 8'h00;
    end else begin
      if (read) begin
        readdata <= address ? rate_view : ctrl_view;
      end
      leds <= disp & {8{pwm_on}};
    end
  end

endmodule

// File: tb/tb_led_pattern_engine.sv
// Self-checking bench for led_pattern_engine: directed scenarios plus random register traffic
// compared against a register-level behavioural model of the LED output and read data.
module tb_led_pattern_engine;
  localparam int PRESCALE = 4;

  logic        clk;
  logic        reset_n;
  logic        address;
  logic        read;
  logic [31:0] readdata;
  logic        write;
  logic [31:0] writedata;
  logic [7:0]  leds;

  int checks   = 0;
  int failures = 0;

  led_pattern_engine #(.PRESCALE(PRESCALE)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .read      (read),
    .readdata  (readdata),
    .write     (write),
    .writedata (writedata),
    .leds      (leds)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout reached before summary");
    $fatal(1, "watchdog");
  end

  // Behavioural model: registers, tick/step bookkeeping in plain integers, outputs from pre-edge state.
  logic [9:0]  m_ctrl;
  logic [31:0] m_rate;
  logic [7:0]  m_work;
  logic        m_phase;
  int          m_ticks;
  int          m_presc;
  int          m_pwm;
  int          m_step;
  logic [7:0]  m_leds;
  logic [31:0] m_rd;
  logic [7:0]  m_disp;
  logic        m_on;
  logic        m_tick;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_ctrl  = 10'd0;
      m_rate  = 32'h0001F4FF;
      m_work  = 8'h00;
      m_phase = 1'b1;
      m_ticks = 0;
      m_presc = 0;
      m_pwm   = 0;
      m_leds  = 8'h00;
      m_rd    = 32'd0;
    end else begin
      m_disp = (m_ctrl[9:8] == 2'b01 && !m_phase) ? 8'h00 : m_work;
      m_on   = (m_pwm < int'(m_rate[7:0])) || (m_rate[7:0] == 8'hFF);
      m_leds = m_on ? m_disp : 8'h00;
      if (read) m_rd = address ? m_rate : {22'd0, m_ctrl};
      m_tick  = (m_presc == PRESCALE - 1);
      m_presc = (m_presc + 1) % PRESCALE;
      m_pwm   = (m_pwm + 1) % 256;
      if (write && !address) begin
        m_ctrl  = writedata[9:0];
        m_work  = writedata[7:0];
        m_phase = 1'b1;
        m_ticks = 0;
      end else if (write) begin
`ifdef LED_PATTERN_ENGINE_PWM_EN
        m_rate = {8'h00, writedata[23:0]};
`else
        m_rate = {8'h00, writedata[23:8], 8'hFF};
`endif
        m_ticks = 0;
      end else if (m_tick) begin
        m_ticks = m_ticks + 1;
        m_step  = (m_rate[23:8] == 16'd0) ? 1 : int'(m_rate[23:8]);
        if (m_ticks >= m_step) begin
          m_ticks = 0;
          case (m_ctrl[9:8])
            2'b01:   m_phase = !m_phase;
            2'b10:   m_work  = (m_work << 1) | (m_work >> 7);
            2'b11:   m_work  = (m_work >> 1) | (m_work << 7);
            default: ;
          endcase
        end
      end
    end
  end

  task automatic wr(input logic a, input logic [31:0] d);
    address = a; writedata = d; write = 1'b1;
    @(negedge clk);
    write = 1'b0;
  endtask

  task automatic rd(input logic a, output logic [31:0] d);
    address = a; read = 1'b1;
    @(negedge clk);
    read = 1'b0;
    d = readdata;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (leds !== 8'h00) begin
        failures++; $display("FAIL reset_leds got=%h want=00", leds);
      end
    end
    checks++;
    if (readdata !== 32'd0) begin
      failures++; $display("FAIL reset_readdata got=%h want=00000000", readdata);
    end
    reset_n = 1'b1;
    rd(1'b0, v);
    checks++;
    if (v !== 32'h00000000) begin
      failures++; $display("FAIL reset_ctrl got=%h want=00000000", v);
    end
    rd(1'b1, v);
    checks++;
    if (v !== 32'h0001F4FF) begin
      failures++; $display("FAIL reset_rate got=%h want=0001f4ff", v);
    end
  endtask

  task automatic test_chase_left();
    logic [7:0] rv[$];
    int rl[$];
    wr(1'b1, 32'h000002FF);
    wr(1'b0, 32'h00000281);
    @(negedge clk);
    for (int i = 0; i < 40; i++) begin
      checks++;
      if (leds !== m_leds) begin
        failures++; $display("FAIL chase_left_leds cyc=%0d got=%h want=%h", i, leds, m_leds);
      end
      if (rv.size() == 0 || rv[rv.size()-1] !== leds) begin
        rv.push_back(leds); rl.push_back(1);
      end else begin
        rl[rl.size()-1]++;
      end
      @(negedge clk);
    end
    checks++;
    if (rv.size() < 4 || rv[0] !== 8'h81 || rv[1] !== 8'h03 || rv[2] !== 8'h06 || rl[1] != 8 || rl[2] != 8) begin
      failures++;
      $display("FAIL chase_left_seq got=%h,%h,%h len=%0d,%0d want=81,03,06 len=8,8",
               rv[0], rv[1], rv[2], rl[1], rl[2]);
    end
  endtask

  task automatic test_blink();
    logic [7:0] rv[$];
    int rl[$];
    wr(1'b1, 32'h000001FF);
    wr(1'b0, 32'h0000015A);
    @(negedge clk);
    for (int i = 0; i < 40; i++) begin
      checks++;
      if (leds !== m_leds) begin
        failures++; $display("FAIL blink_leds cyc=%0d got=%h want=%h", i, leds, m_leds);
      end
      if (rv.size() == 0 || rv[rv.size()-1] !== leds) begin
        rv.push_back(leds); rl.push_back(1);
      end else begin
        rl[rl.size()-1]++;
      end
      @(negedge clk);
    end
    checks++;
    if (rv.size() < 5 || rv[0] !== 8'h5A || rv[1] !== 8'h00 || rv[2] !== 8'h5A || rv[3] !== 8'h00 ||
        rl[1] != 4 || rl[2] != 4 || rl[3] != 4) begin
      failures++;
      $display("FAIL blink_seq got=%h,%h,%h,%h len=%0d,%0d,%0d want=5a,00,5a,00 len=4,4,4",
               rv[0], rv[1], rv[2], rv[3], rl[1], rl[2], rl[3]);
    end
  endtask

  task automatic test_pwm();
    int on_cnt = 0;
    int want;
    wr(1'b1, 32'h00000140);
    wr(1'b0, 32'h000000FF);
    @(negedge clk);
    for (int i = 0; i < 256; i++) begin
      checks++;
      if (leds !== m_leds) begin
        failures++; $display("FAIL pwm_leds cyc=%0d got=%h want=%h", i, leds, m_leds);
      end
      if (leds === 8'hFF) on_cnt++;
      @(negedge clk);
    end
`ifdef LED_PATTERN_ENGINE_PWM_EN
    want = 64;
`else
    want = 256;
`endif
    checks++;
    if (on_cnt != want) begin
      failures++; $display("FAIL pwm_on_cycles got=%0d want=%0d", on_cnt, want);
    end
  endtask

  task automatic test_rw_same_cycle();
    logic [31:0] v;
    wr(1'b0, 32'h00000012);
    address = 1'b0; read = 1'b1; write = 1'b1; writedata = 32'h00000034;
    @(negedge clk);
    read = 1'b0; write = 1'b0;
    checks++;
    if (readdata !== 32'h00000012) begin
      failures++; $display("FAIL rw_same_old got=%h want=00000012", readdata);
    end
    rd(1'b0, v);
    checks++;
    if (v !== 32'h00000034) begin
      failures++; $display("FAIL rw_same_new got=%h want=00000034", v);
    end
  endtask

  task automatic test_random();
    int op;
    for (int i = 0; i < 500; i++) begin
      op = $urandom_range(0, 15);
      read = 1'b0; write = 1'b0;
      if (op == 0) begin
        address = 1'b0; writedata = $urandom; write = 1'b1; read = 1'($urandom_range(0, 1));
      end else if (op == 1) begin
        address = 1'b1;
        writedata = {8'($urandom), 16'($urandom_range(0, 3)), 8'($urandom)};
        write = 1'b1;
      end else if (op <= 5) begin
        address = 1'($urandom_range(0, 1)); read = 1'b1;
      end
      @(negedge clk);
      read = 1'b0; write = 1'b0;
      checks++;
      if (leds !== m_leds) begin
        failures++; $display("FAIL random_leds it=%0d got=%h want=%h", i, leds, m_leds);
      end
      checks++;
      if (readdata !== m_rd) begin
        failures++; $display("FAIL random_readdata it=%0d got=%h want=%h", i, readdata, m_rd);
      end
    end
  endtask

  task automatic test_reset_mid_chase();
    logic [31:0] v;
    wr(1'b1, 32'h000001FF);
    wr(1'b0, 32'h00000201);
    repeat (10) @(negedge clk);
    checks++;
    if (leds !== m_leds || leds === 8'h00) begin
      failures++; $display("FAIL pre_reset_leds got=%h want=%h (nonzero)", leds, m_leds);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (leds !== 8'h00) begin
      failures++; $display("FAIL async_reset_leds got=%h want=00", leds);
    end
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (leds !== 8'h00) begin
        failures++; $display("FAIL held_reset_leds got=%h want=00", leds);
      end
    end
    reset_n = 1'b1;
    rd(1'b0, v);
    checks++;
    if (v !== 32'h00000000) begin
      failures++; $display("FAIL post_reset_ctrl got=%h want=00000000", v);
    end
    rd(1'b1, v);
    checks++;
    if (v !== 32'h0001F4FF) begin
      failures++; $display("FAIL post_reset_rate got=%h want=0001f4ff", v);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (leds !== m_leds) begin
        failures++; $display("FAIL post_reset_leds cyc=%0d got=%h want=%h", i, leds, m_leds);
      end
    end
  endtask

  initial begin
    reset_n = 1'b0; address = 1'b0; read = 1'b0; write = 1'b0; writedata = 32'd0;
    test_reset();
    test_chase_left();
    test_blink();
    test_pwm();
    test_rw_same_cycle();
    test_random();
    test_reset_mid_chase();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
